// File: rtl/p2l_pkg.sv
// p2l_pkg: shared state encoding and mode constants for the pulse-to-level converter
package p2l_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    GAP    = 2'd2,
    T_HIGH = 2'd3
  } p2l_state_t;
  localparam logic MODE_STRETCH = 1'b0;
  localparam logic MODE_TOGGLE  = 1'b1;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: up/down counter that sticks at both ends and flags increments lost at the top
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_hit
);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  logic up, dn;
  assign up      = inc & ~dec;
  assign dn      = dec & ~inc;
  assign sat_hit = up && count == MAX;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      count <= '0;
    else if (up && count != MAX)
      count <= count + ONE;
    else if (dn && count != '0)
      count <= count - ONE;
endmodule

// File: rtl/pulse_to_level_converter.sv
// pulse_to_level_converter: stretches request pulses into timed levels with queued retrigger,
// or toggles the level per pulse
module pulse_to_level_converter
  import p2l_pkg::*;
#(
  parameter int HOLD_W     = 8,
  parameter int GAP_CYCLES = 1,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              mode,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              overflow
);
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        GAP_LOAD = 8'(GAP_CYCLES);
  p2l_state_t        state, nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_load;
  logic [7:0]        gap_cnt, gap_nxt;
  logic              inc, dec, sat_hit;
  // a zero hold length still produces a visible one-cycle level
  assign hold_load = (hold_len == '0) ? HOLD_ONE : hold_len;
  sat_updown_counter #(.W(PEND_W)) u_pend (
    .clk    (clk),
    .reset  (reset),
    .inc    (inc),
    .dec    (dec),
    .count  (pending_cnt),
    .sat_hit(sat_hit)
  );
  always_comb begin
    nxt      = state;
    hold_nxt = hold_cnt;
    gap_nxt  = gap_cnt;
    inc      = 1'b0;
    dec      = 1'b0;
    case (state)
      IDLE:
        if (pulse_in) begin
          nxt      = (mode == MODE_TOGGLE) ? T_HIGH : HIGH;
          hold_nxt = (mode == MODE_TOGGLE) ? hold_cnt : hold_load;
        end
      HIGH: begin
        inc      = pulse_in;
        hold_nxt = hold_cnt - HOLD_ONE;
        if (hold_cnt <= HOLD_ONE) begin
          nxt     = GAP;
          gap_nxt = GAP_LOAD;
        end
      end
      GAP: begin
        gap_nxt = gap_cnt - 8'd1;
        if (gap_cnt > 8'd1)
          inc = pulse_in;
        else if (pending_cnt != '0) begin
          // queued work is served first; a new pulse here just joins the queue
          nxt      = HIGH;
          hold_nxt = hold_load;
          dec      = 1'b1;
          inc      = pulse_in;
        end else if (pulse_in) begin
          nxt      = HIGH;
          hold_nxt = hold_load;
        end else
          nxt = IDLE;
      end
      T_HIGH:
        if (pulse_in || mode == MODE_STRETCH)
          nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      level_out <= nxt == HIGH || nxt == T_HIGH;
      busy      <= nxt == HIGH || nxt == GAP;
      overflow  <= sat_hit ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
endmodule

// File: tb/tb_pulse_to_level_converter.sv
// tb_pulse_to_level_converter: directed per-cycle vectors; expected outputs queued by the driver,
// compared by an independent negedge monitor
module tb_pulse_to_level_converter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic [7:0] hold_len = 8'd3;
  logic       mode = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       level_out, busy, overflow;
  logic [1:0] pending_cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic       l;
    logic       b;
    logic [1:0] p;
    logic       o;
    string      n;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  pulse_to_level_converter #(.HOLD_W(8), .GAP_CYCLES(1), .PEND_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .hold_len   (hold_len),
    .mode       (mode),
    .clr_ovf    (clr_ovf),
    .level_out  (level_out),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({level_out, busy, pending_cnt, overflow} !== {e.l, e.b, e.p, e.o}) begin
        failures++;
        $display("FAIL %s: got lvl=%b busy=%b pend=%0d ovf=%b want lvl=%b busy=%b pend=%0d ovf=%b",
                 e.n, level_out, busy, pending_cnt, overflow, e.l, e.b, e.p, e.o);
      end
    end
  task automatic s(input logic r, p, m, c, input logic el, eb, input logic [1:0] ep,
                   input logic eo, input string n);
    @(posedge clk);
    #1;
    reset    = r;
    pulse_in = p;
    mode     = m;
    clr_ovf  = c;
    q.push_back('{el, eb, ep, eo, n});
  endtask
  task automatic idle(input int k, input logic m, input string n);
    for (int i = 0; i < k; i++) s(0, 0, m, 0, 0, 0, 0, 0, n);
  endtask
  initial begin
    s(1, 0, 0, 0, 0, 0, 0, 0, "reset_state");
    idle(4, 0, "idle");
    s(0, 1, 0, 0, 0, 0, 0, 0, "basic_c5");
    s(0, 0, 0, 0, 1, 1, 0, 0, "basic_c6");
    s(0, 0, 0, 0, 1, 1, 0, 0, "basic_c7");
    s(0, 0, 0, 0, 1, 1, 0, 0, "basic_c8");
    s(0, 0, 0, 0, 0, 1, 0, 0, "basic_gap_c9");
    s(0, 0, 0, 0, 0, 0, 0, 0, "basic_idle_c10");
    hold_len = 8'd2;
    idle(2, 0, "idle");
    s(0, 1, 0, 0, 0, 0, 0, 0, "b2b_c5");
    s(0, 1, 0, 0, 1, 1, 0, 0, "b2b_c6");
    s(0, 1, 0, 0, 1, 1, 1, 0, "b2b_c7");
    s(0, 0, 0, 0, 0, 1, 2, 0, "b2b_gap1");
    s(0, 0, 0, 0, 1, 1, 1, 0, "b2b_c9");
    s(0, 0, 0, 0, 1, 1, 1, 0, "b2b_c10");
    s(0, 0, 0, 0, 0, 1, 1, 0, "b2b_gap2");
    s(0, 0, 0, 0, 1, 1, 0, 0, "b2b_c12");
    s(0, 0, 0, 0, 1, 1, 0, 0, "b2b_c13");
    s(0, 0, 0, 0, 0, 1, 0, 0, "b2b_gap3");
    s(0, 0, 0, 0, 0, 0, 0, 0, "b2b_idle");
    hold_len = 8'd0;
    s(0, 1, 0, 0, 0, 0, 0, 0, "h0_pulse");
    s(0, 0, 0, 0, 1, 1, 0, 0, "h0_high");
    s(0, 0, 0, 0, 0, 1, 0, 0, "h0_gap");
    s(0, 0, 0, 0, 0, 0, 0, 0, "h0_idle");
    hold_len = 8'd2;
    s(0, 1, 0, 0, 0, 0, 0, 0, "gp0_pulse");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp0_h1");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp0_h2");
    s(0, 1, 0, 0, 0, 1, 0, 0, "gp0_gap_pulse");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp0_rehigh1");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp0_rehigh2");
    s(0, 0, 0, 0, 0, 1, 0, 0, "gp0_gap2");
    s(0, 0, 0, 0, 0, 0, 0, 0, "gp0_idle");
    s(0, 1, 0, 0, 0, 0, 0, 0, "gp1_pulse");
    s(0, 1, 0, 0, 1, 1, 0, 0, "gp1_h1");
    s(0, 0, 0, 0, 1, 1, 1, 0, "gp1_h2");
    s(0, 1, 0, 0, 0, 1, 1, 0, "gp1_gap_pulse");
    s(0, 0, 0, 0, 1, 1, 1, 0, "gp1_pend_kept");
    s(0, 0, 0, 0, 1, 1, 1, 0, "gp1_h4");
    s(0, 0, 0, 0, 0, 1, 1, 0, "gp1_gap2");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp1_drain1");
    s(0, 0, 0, 0, 1, 1, 0, 0, "gp1_drain2");
    s(0, 0, 0, 0, 0, 1, 0, 0, "gp1_gap3");
    s(0, 0, 0, 0, 0, 0, 0, 0, "gp1_idle");
    hold_len = 8'd10;
    s(0, 1, 0, 0, 0, 0, 0, 0, "sat_start");
    s(0, 1, 0, 0, 1, 1, 0, 0, "sat_p1");
    s(0, 1, 0, 0, 1, 1, 1, 0, "sat_p2");
    s(0, 1, 0, 0, 1, 1, 2, 0, "sat_p3");
    s(0, 1, 0, 0, 1, 1, 3, 0, "sat_p4");
    s(0, 1, 0, 1, 1, 1, 3, 1, "sat_ovf_set");
    s(0, 0, 0, 1, 1, 1, 3, 1, "sat_set_wins");
    s(0, 0, 0, 0, 1, 1, 3, 0, "sat_cleared");
    s(1, 0, 0, 0, 0, 0, 0, 0, "sat_reset");
    idle(4, 1, "tog_idle");
    s(0, 1, 1, 0, 0, 0, 0, 0, "tog_c5");
    s(0, 0, 1, 0, 1, 0, 0, 0, "tog_c6");
    s(0, 0, 1, 0, 1, 0, 0, 0, "tog_c7");
    s(0, 0, 1, 0, 1, 0, 0, 0, "tog_c8");
    s(0, 1, 1, 0, 1, 0, 0, 0, "tog_c9");
    s(0, 0, 1, 0, 0, 0, 0, 0, "tog_c10");
    s(0, 1, 1, 0, 0, 0, 0, 0, "tog_again");
    s(0, 0, 0, 0, 1, 0, 0, 0, "tog_mode_switch");
    s(0, 0, 0, 0, 0, 0, 0, 0, "tog_mode_low");
    s(0, 1, 0, 0, 0, 0, 0, 0, "rst_start");
    s(0, 1, 0, 0, 1, 1, 0, 0, "rst_p1");
    s(0, 1, 0, 0, 1, 1, 1, 0, "rst_p2");
    s(0, 0, 0, 0, 1, 1, 2, 0, "rst_pend_pre");
    s(1, 0, 0, 0, 0, 0, 0, 0, "rst_async");
    s(0, 0, 0, 0, 0, 0, 0, 0, "rst_release");
    hold_len = 8'd3;
    s(0, 1, 0, 0, 0, 0, 0, 0, "post_pulse");
    s(0, 0, 0, 0, 1, 1, 0, 0, "post_h1");
    s(0, 0, 0, 0, 1, 1, 0, 0, "post_h2");
    s(0, 0, 0, 0, 1, 1, 0, 0, "post_h3");
    s(0, 0, 0, 0, 0, 1, 0, 0, "post_gap");
    s(0, 0, 0, 0, 0, 0, 0, 0, "post_idle");
    repeat (2) @(posedge clk);
    #1 pulse_in = 1'b1;
    @(posedge clk);
    #1 pulse_in = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (level_out !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre: got lvl=%b want lvl=1", level_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({level_out, busy, pending_cnt, overflow} !== 5'b0) begin
      failures++;
      $display("FAIL arst_immediate: got lvl=%b busy=%b pend=%0d ovf=%b want all 0",
               level_out, busy, pending_cnt, overflow);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
